vgpr_wr_port_arbiter: RTL and testbench

VGPR_WR_PORT_ARBITER -- requirements
Module: vgpr_wr_port_arbiter

---
 rtl/vgpr_wr_port_arbiter_pkg.sv | 15 +
 rtl/vgpr_wr_port_arbiter_dff.sv | 18 +
 rtl/vgpr_wr_port_arbiter_rr_pick.sv | 28 ++
 rtl/vgpr_wr_port_arbiter.sv | 114 +++++++++++
 tb/tb_vgpr_wr_port_arbiter.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vgpr_wr_port_arbiter_pkg.sv
// Shared VGPR write-port definitions: default geometry and write-enable width.
package vgpr_wr_port_arbiter_pkg;

  localparam int VGPR_NUM_REQ = 4;
  localparam int VGPR_ADDR_W  = 10;
  localparam int VGPR_DATA_W  = 32;
  localparam int VGPR_WEN_W   = 4;
  localparam int VGPR_NUM_RD  = 3;

  // Pointer width, never zero so a single-requester build still elaborates.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vgpr_wr_port_arbiter_dff.sv
// Generic enabled D flip-flop cell with asynchronous active-high reset.
module dff #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= RST_VAL;
    else if (en) q <= d;
  end

endmodule

// File: rtl/vgpr_wr_port_arbiter_rr_pick.sv
// Round-robin picker: one-hot grant to the first requester after ptr, wrapping.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic [PW-1:0] idx;
  logic          found;

  // ptr itself is visited last, so the previous winner has lowest priority.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int off = 1; off <= N; off++) begin
      idx = PW'((int'(ptr) + off) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vgpr_wr_port_arbiter.sv
// VGPR write-port arbiter: round-robin grant, one registered write per cycle,
// and read-after-write hazard flags covering the grant and write stages.
module vgpr_wr_port_arbiter
  import vgpr_wr_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ = VGPR_NUM_REQ,
  parameter int ADDR_W  = VGPR_ADDR_W,
  parameter int DATA_W  = VGPR_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ*4-1:0]      req_en,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [ADDR_W-1:0]         wr0_addr,
  output logic [3:0]                wr0_en,
  output logic [DATA_W-1:0]         wr0_data,
  input  logic [ADDR_W-1:0]         rd0_addr,
  input  logic [ADDR_W-1:0]         rd1_addr,
  input  logic [ADDR_W-1:0]         rd2_addr,
  output logic [VGPR_NUM_RD-1:0]    rd_hazard,
  input  logic                      flush
);

  localparam int          PW       = ptr_w(NUM_REQ);
  localparam int          EW       = VGPR_WEN_W;
  localparam logic [PW-1:0] PTR_INIT = PW'(NUM_REQ - 1);

  logic [NUM_REQ-1:0][ADDR_W-1:0] addr_v;
  logic [NUM_REQ-1:0][DATA_W-1:0] data_v;
  logic [NUM_REQ-1:0][EW-1:0]     en_v;
  logic [VGPR_NUM_RD-1:0][ADDR_W-1:0] rd_v;

  assign addr_v = req_addr;
  assign data_v = req_data;
  assign en_v   = req_en;
  assign rd_v   = {rd2_addr, rd1_addr, rd0_addr};

  logic [PW-1:0]      last_grant;
  logic [PW-1:0]      grant_idx;
  logic [NUM_REQ-1:0] gnt;
  logic               xfer;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;
  logic [EW-1:0]      sel_en;

  rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
    .req (req_valid),
    .ptr (last_grant),
    .gnt (gnt)
  );

  // Nothing transfers during reset or flush; the pick itself is left untouched.
  assign req_ready = (rst || flush) ? '0 : gnt;
  assign xfer      = |req_ready;

  always_comb begin
    sel_addr  = '0;
    sel_data  = '0;
    sel_en    = '0;
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        sel_addr  = addr_v[i];
        sel_data  = data_v[i];
        sel_en    = en_v[i];
        grant_idx = PW'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       last_grant <= PTR_INIT;
    else if (flush) last_grant <= PTR_INIT;
    else if (xfer)  last_grant <= grant_idx;
  end

  // Enable reloads every cycle so it self-clears; address/data only on a transfer.
  dff #(.W(EW)) u_wr_en (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .d   (xfer ? sel_en : '0),
    .q   (wr0_en)
  );

  dff #(.W(ADDR_W)) u_wr_addr (
    .clk (clk),
    .rst (rst),
    .en  (xfer),
    .d   (sel_addr),
    .q   (wr0_addr)
  );

  dff #(.W(DATA_W)) u_wr_data (
    .clk (clk),
    .rst (rst),
    .en  (xfer),
    .d   (sel_data),
    .q   (wr0_data)
  );

  logic wr_live, grant_live;
  assign wr_live    = |wr0_en;
  assign grant_live = xfer && |sel_en;

  for (genvar k = 0; k < VGPR_NUM_RD; k++) begin : g_hz
    assign rd_hazard[k] = (wr_live    && (rd_v[k] == wr0_addr)) ||
                          (grant_live && (rd_v[k] == sel_addr));
  end

endmodule

// File: tb/tb_vgpr_wr_port_arbiter.sv
// Bench for vgpr_wr_port_arbiter: directed scenarios plus random traffic
// checked against a transaction-level model.
module tb_vgpr_wr_port_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic [3:0]   req_valid = '0;
  logic [39:0]  req_addr = '0;
  logic [127:0] req_data = '0;
  logic [15:0]  req_en = '0;
  logic [9:0]   rd0_addr = '0, rd1_addr = '0, rd2_addr = '0;
  logic [3:0]   req_ready;
  logic [9:0]   wr0_addr;
  logic [3:0]   wr0_en;
  logic [31:0]  wr0_data;
  logic [2:0]   rd_hazard;

  int checks = 0;
  int errors = 0;

  // model state: round-robin pointer and the write currently on the port
  int         m_last;
  logic [9:0] m_waddr;
  logic [31:0] m_wdata;
  logic [3:0] m_wen;

  vgpr_wr_port_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_en    (req_en),
    .req_ready (req_ready),
    .wr0_addr  (wr0_addr),
    .wr0_en    (wr0_en),
    .wr0_data  (wr0_data),
    .rd0_addr  (rd0_addr),
    .rd1_addr  (rd1_addr),
    .rd2_addr  (rd2_addr),
    .rd_hazard (rd_hazard),
    .flush     (flush)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [3:0] v, input int last, input logic fl);
    if (fl) return -1;
    for (int off = 1; off <= 4; off++) begin
      int i;
      i = (last + off) % 4;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; flush = 1'b0; req_valid = '0; req_en = '0;
    rd0_addr = 10'h3ff; rd1_addr = 10'h3ff; rd2_addr = 10'h3ff;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = 4'b1111; req_en = 16'hffff; req_addr = '0;
    rd0_addr = 10'h000;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
    checks++;
    if (wr0_en !== 4'h0 || wr0_addr !== 10'h0 || wr0_data !== 32'h0) begin
      errors++; $display("FAIL reset_wr0: got en=%h addr=%h data=%h expected zeros", wr0_en, wr0_addr, wr0_data);
    end
    checks++;
    if (rd_hazard !== 3'b000) begin errors++; $display("FAIL reset_hazard: got %b expected 000", rd_hazard); end
    req_valid = '0;
  endtask

  task automatic test_round_robin();
    do_reset();
    req_valid = 4'b1111; req_en = 16'hffff;
    for (int i = 0; i < 4; i++) req_addr[i*10 +: 10] = 10'(16 + i);
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (req_ready !== 4'(1 << (c % 4))) begin
        errors++; $display("FAIL rr_grant[%0d]: got %b expected %b", c, req_ready, 4'(1 << (c % 4)));
      end
      if (c >= 1) begin
        checks++;
        if (wr0_en !== 4'hf || wr0_addr !== 10'(16 + (c - 1) % 4)) begin
          errors++; $display("FAIL rr_write[%0d]: got en=%h addr=%h expected en=f addr=%h", c, wr0_en, wr0_addr, 10'(16 + (c - 1) % 4));
        end
      end
      @(negedge clk);
    end
    req_valid = '0;
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0010;
    req_addr[10 +: 10] = 10'h155; req_data[32 +: 32] = 32'hdeadbeef; req_en[4 +: 4] = 4'hf;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("FAIL single_ready: got %b expected 0010", req_ready); end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++;
    if (wr0_addr !== 10'h155 || wr0_data !== 32'hdeadbeef || wr0_en !== 4'hf) begin
      errors++; $display("FAIL single_write: got addr=%h data=%h en=%h expected 155 deadbeef f", wr0_addr, wr0_data, wr0_en);
    end
  endtask

  task automatic test_hazard();
    do_reset();
    req_valid = 4'b0100; req_addr[20 +: 10] = 10'h020; req_en[8 +: 4] = 4'hf;
    rd0_addr = 10'h021; rd1_addr = 10'h020; rd2_addr = 10'h100;
    #1;
    checks++;
    if (rd_hazard !== 3'b010) begin errors++; $display("FAIL hazard_grant: got %b expected 010", rd_hazard); end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++;
    if (rd_hazard !== 3'b010) begin errors++; $display("FAIL hazard_write: got %b expected 010", rd_hazard); end
    @(negedge clk);
    #1;
    checks++;
    if (rd_hazard !== 3'b000) begin errors++; $display("FAIL hazard_idle: got %b expected 000", rd_hazard); end
  endtask

  task automatic test_zero_en();
    do_reset();
    req_valid = 4'b0001; req_addr[0 +: 10] = 10'h005; req_en[0 +: 4] = 4'h0;
    rd0_addr = 10'h005;
    #1;
    checks++;
    if (req_ready !== 4'b0001 || rd_hazard !== 3'b000) begin
      errors++; $display("FAIL zero_en_accept: got ready=%b hz=%b expected 0001 000", req_ready, rd_hazard);
    end
    @(negedge clk);
    req_valid = 4'b0011; req_en[3:0] = 4'hf; req_en[7:4] = 4'hf;
    #1;
    checks++;
    if (wr0_en !== 4'h0) begin errors++; $display("FAIL zero_en_write: got %h expected 0", wr0_en); end
    checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("FAIL zero_en_next: got %b expected 0010", req_ready); end
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic test_flush();
    do_reset();
    req_valid = 4'b1111; req_en = 16'hffff;
    @(negedge clk);
    flush = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin errors++; $display("FAIL flush_ready: got %b expected 0000", req_ready); end
    @(negedge clk);
    flush = 1'b0;
    #1;
    checks++;
    if (wr0_en !== 4'h0) begin errors++; $display("FAIL flush_write: got %h expected 0", wr0_en); end
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL flush_ptr: got %b expected 0001", req_ready); end
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic test_rst_mid();
    do_reset();
    req_valid = 4'b0001; req_addr[0 +: 10] = 10'h033; req_en[0 +: 4] = 4'hf;
    @(posedge clk);
    #1;
    checks++;
    if (wr0_en !== 4'hf) begin errors++; $display("FAIL rstmid_loaded: got %h expected f", wr0_en); end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (wr0_en !== 4'h0 || wr0_addr !== 10'h0) begin
      errors++; $display("FAIL rstmid_drop: got en=%h addr=%h expected 0 0", wr0_en, wr0_addr);
    end
    @(negedge clk);
    rst = 1'b0; req_valid = '0;
    @(posedge clk);
    #1;
    checks++;
    if (wr0_en !== 4'h0) begin errors++; $display("FAIL rstmid_noissue: got %h expected 0", wr0_en); end
  endtask

  task automatic test_random();
    int g, prev_g;
    logic [3:0] exp_rdy;
    logic [2:0] exp_hz;
    logic [9:0] rd [3];
    do_reset();
    m_last = 3; m_waddr = '0; m_wdata = '0; m_wen = '0;
    prev_g = -1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc != 0) @(negedge clk);
      if (prev_g >= 0) req_valid[prev_g] = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) != 0) begin
          req_valid[i] = 1'b1;
          req_addr[i*10 +: 10] = 10'($urandom_range(0, 7));
          req_data[i*32 +: 32] = $urandom;
          req_en[i*4 +: 4] = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom);
        end
      end
      flush = ($urandom_range(0, 15) == 0);
      rd0_addr = 10'($urandom_range(0, 7));
      rd1_addr = 10'($urandom_range(0, 7));
      rd2_addr = 10'($urandom_range(0, 7));
      #1;
      g = pick(req_valid, m_last, flush);
      exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
      rd[0] = rd0_addr; rd[1] = rd1_addr; rd[2] = rd2_addr;
      for (int k = 0; k < 3; k++)
        exp_hz[k] = (m_wen != 0 && rd[k] == m_waddr) ||
                    (g >= 0 && req_en[g*4 +: 4] != 0 && rd[k] == req_addr[g*10 +: 10]);
      checks++;
      if (req_ready !== exp_rdy) begin errors++; $display("FAIL rand_ready[%0d]: got %b expected %b", cyc, req_ready, exp_rdy); end
      checks++;
      if (rd_hazard !== exp_hz) begin errors++; $display("FAIL rand_hazard[%0d]: got %b expected %b", cyc, rd_hazard, exp_hz); end
      checks++;
      if (wr0_en !== m_wen || wr0_addr !== m_waddr || wr0_data !== m_wdata) begin
        errors++; $display("FAIL rand_write[%0d]: got en=%h addr=%h data=%h expected en=%h addr=%h data=%h",
                           cyc, wr0_en, wr0_addr, wr0_data, m_wen, m_waddr, m_wdata);
      end
      @(posedge clk);
      if (g >= 0) begin
        m_last  = g;
        m_wen   = req_en[g*4 +: 4];
        m_waddr = req_addr[g*10 +: 10];
        m_wdata = req_data[g*32 +: 32];
      end else begin
        m_wen = '0;
      end
      if (flush) m_last = 3;
      prev_g = g;
    end
    @(negedge clk);
    flush = 1'b0; req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_hazard();
    test_zero_en();
    test_flush();
    test_rst_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
